// File: rtl/search_ctrl.sv
// search_ctrl -- iterative-deepening depth-first search sequencer.
//
// Walks every non-redundant move sequence of length 0..MAX_DEPTH, shortest
// first, driving the cube datapath one move at a time through a valid/ready
// port. The search stops on the first sequence after which the datapath reports
// the cube as solved. That sequence is then left in the move stack for readout.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 start request (rising edge only)
//   op_valid/op_undo    move request; op_undo=1 applies the inverse move
//   op_face/op_turn     move: face 0..5, turn 1=CW 2=half 3=CCW
//   op_ready            datapath accepted the move this cycle
//   solved              datapath cube state is solved (level)
//   busy/done/found     search status; found is valid while done=1
//   depth               solution length, or the current limit while busy
//   rd_addr/rd_face/rd_turn  combinational stack readout
module search_ctrl #(
  parameter int MAX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       op_valid,
  output logic       op_undo,
  output logic [2:0] op_face,
  output logic [1:0] op_turn,
  input  logic       op_ready,
  input  logic       solved,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [3:0] depth,
  input  logic [3:0] rd_addr,
  output logic [2:0] rd_face,
  output logic [1:0] rd_turn
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_APPLY, S_UNDO, S_ADVANCE, S_BACKTRACK, S_DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] lim_reg, lv_reg, depth_reg;
  logic       found_reg, run_d_reg;
  logic [2:0] stack_face [MAX_DEPTH];
  logic [1:0] stack_turn [MAX_DEPTH];

  // Stack write port (always addressed by lv).
  logic       wr_en;
  logic [2:0] wr_face;
  logic [1:0] wr_turn;

  logic       start;
  logic [2:0] cur_face, prev_face, undo_face;
  logic [1:0] cur_turn, undo_turn;
  logic       has_prev;
  logic [2:0] first_face;
  logic [3:0] nf1, nf;
  logic       nf_ok;
  logic [4:0] lim_inc;
  logic       lim_over;

  // Out-of-range indices (e.g. lv-1 with lv=0) read as entry {0,0}.
  function automatic logic [2:0] face_at(input logic [3:0] idx);
    face_at = '0;
    for (int i = 0; i < MAX_DEPTH; i++)
      if (idx == 4'(i)) face_at = stack_face[i];
  endfunction

  function automatic logic [1:0] turn_at(input logic [3:0] idx);
    turn_at = '0;
    for (int i = 0; i < MAX_DEPTH; i++)
      if (idx == 4'(i)) turn_at = stack_turn[i];
  endfunction

  always_comb begin
    start     = run & ~run_d_reg;
    cur_face  = face_at(lv_reg);
    cur_turn  = turn_at(lv_reg);
    undo_face = face_at(lv_reg - 4'd1);
    undo_turn = turn_at(lv_reg - 4'd1);
    prev_face = undo_face;
    has_prev  = (lv_reg != 4'd0);
    // Turning the same face twice in a row is redundant, so the face just
    // below the current level is skipped.
    first_face = (has_prev && prev_face == 3'd0) ? 3'd1 : 3'd0;
    nf1        = {1'b0, cur_face} + 4'd1;
    nf         = (has_prev && nf1 == {1'b0, prev_face}) ? nf1 + 4'd1 : nf1;
    nf_ok      = (nf <= 4'd5);
    lim_inc    = {1'b0, lim_reg} + 5'd1;
    lim_over   = (lim_inc > 5'(MAX_DEPTH));
    rd_face    = face_at(rd_addr);
    rd_turn    = turn_at(rd_addr);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start) state_next = S_CHECK;
      S_CHECK: begin
        if (solved)                state_next = S_DONE;
        else if (lv_reg < lim_reg) state_next = S_APPLY;
        else                       state_next = S_BACKTRACK;
      end
      S_APPLY: if (op_ready) state_next = S_CHECK;
      S_UNDO:  if (op_ready) state_next = S_ADVANCE;
      S_ADVANCE: begin
        if (cur_turn != 2'd3 || nf_ok) state_next = S_APPLY;
        else                           state_next = S_BACKTRACK;
      end
      S_BACKTRACK: begin
        if (!has_prev) state_next = lim_over ? S_DONE : S_CHECK;
        else           state_next = S_UNDO;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs, decoded from the state so an asynchronous reset clears them at once.
  always_comb begin
    op_valid = 1'b0;
    op_undo  = 1'b0;
    op_face  = 3'd0;
    op_turn  = 2'd0;
    case (state_reg)
      S_APPLY: begin
        op_valid = 1'b1;
        op_face  = cur_face;
        op_turn  = cur_turn;
      end
      S_UNDO: begin
        op_valid = 1'b1;
        op_undo  = 1'b1;
        op_face  = undo_face;
        op_turn  = undo_turn;
      end
      default: ;
    endcase
    busy  = (state_reg != S_IDLE) && (state_reg != S_DONE);
    done  = (state_reg == S_DONE);
    found = found_reg;
    depth = busy ? lim_reg : depth_reg;
  end

  // Stack write selection: seed a new level in CHECK, step it in ADVANCE.
  always_comb begin
    wr_en   = 1'b0;
    wr_face = cur_face;
    wr_turn = cur_turn;
    case (state_reg)
      S_CHECK: begin
        if (!solved && lv_reg < lim_reg) begin
          wr_en   = 1'b1;
          wr_face = first_face;
          wr_turn = 2'd1;
        end
      end
      S_ADVANCE: begin
        if (cur_turn != 2'd3) begin
          wr_en   = 1'b1;
          wr_turn = cur_turn + 2'd1;
        end else if (nf_ok) begin
          wr_en   = 1'b1;
          wr_face = nf[2:0];
          wr_turn = 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Search counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lim_reg   <= '0;
      lv_reg    <= '0;
      depth_reg <= '0;
      found_reg <= 1'b0;
      run_d_reg <= 1'b0;
    end else begin
      run_d_reg <= run;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            lim_reg   <= '0;
            lv_reg    <= '0;
            depth_reg <= '0;
            found_reg <= 1'b0;
          end
        end
        S_CHECK: begin
          if (solved) begin
            found_reg <= 1'b1;
            depth_reg <= lv_reg;
          end
        end
        S_APPLY: if (op_ready) lv_reg <= lv_reg + 4'd1;
        S_UNDO:  if (op_ready) lv_reg <= lv_reg - 4'd1;
        S_BACKTRACK: begin
          if (!has_prev) begin
            // On exhaustion, report the deepest limit that was searched.
            if (lim_over) depth_reg <= 4'(MAX_DEPTH);
            else          lim_reg   <= lim_inc[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Move stack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stack_face[i] <= '0;
        stack_turn[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        if (wr_en && lv_reg == 4'(i)) begin
          stack_face[i] <= wr_face;
          stack_turn[i] <= wr_turn;
        end
      end
    end
  end

endmodule

// File: tb/tb_search_ctrl.sv
module tb_search_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, run8, run2, op_ready, solved;
  logic [3:0] rd_addr;
  logic       v8, u8, b8, d8, fd8, v2, u2, b2, d2, fd2;
  logic [2:0] f8, rf8, f2, rf2;
  logic [1:0] t8, rt8, t2, rt2;
  logic [3:0] dp8, dp2;

  search_ctrl #(.MAX_DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .run(run8), .op_valid(v8), .op_undo(u8),
    .op_face(f8), .op_turn(t8), .op_ready(op_ready), .solved(solved),
    .busy(b8), .done(d8), .found(fd8), .depth(dp8), .rd_addr(rd_addr),
    .rd_face(rf8), .rd_turn(rt8)
  );

  search_ctrl #(.MAX_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2), .op_valid(v2), .op_undo(u2),
    .op_face(f2), .op_turn(t2), .op_ready(op_ready), .solved(solved),
    .busy(b2), .done(d2), .found(fd2), .depth(dp2), .rd_addr(rd_addr),
    .rd_face(rf2), .rd_turn(rt2)
  );

  // Selected DUT view.
  bit sel2;
  logic       op_valid, op_undo, busy, done, found;
  logic [2:0] op_face, rd_face;
  logic [1:0] op_turn, rd_turn;
  logic [3:0] depth;
  assign op_valid = sel2 ? v2  : v8;
  assign op_undo  = sel2 ? u2  : u8;
  assign op_face  = sel2 ? f2  : f8;
  assign op_turn  = sel2 ? t2  : t8;
  assign busy     = sel2 ? b2  : b8;
  assign done     = sel2 ? d2  : d8;
  assign found    = sel2 ? fd2 : fd8;
  assign depth    = sel2 ? dp2 : dp8;
  assign rd_face  = sel2 ? rf2 : rf8;
  assign rd_turn  = sel2 ? rt2 : rt8;

  // Scenario configuration (written by the stimulus process only).
  bit         tie_solved;
  int         ready_mode;   // 0 always ready, 1 random 30%, 2 never
  int         tgt_len;
  logic [2:0] tgt_face [4];
  logic [1:0] tgt_turn [4];

  // Cube datapath model (written by the model process only).
  int         m_depth, n_apply, n_undo, prune_err, undo_err, stab_err;
  logic [2:0] m_face [16];
  logic [1:0] m_turn [16];
  bit         solved_m, prev_stall, match;
  logic [2:0] pf;
  logic [1:0] pt;
  logic       pu;

  assign solved = tie_solved | solved_m;

  // Handshakes complete at the next posedge when op_valid & op_ready hold at
  // this negedge, so the model applies them here.
  always @(negedge clk) begin
    if (run8 || run2) begin
      m_depth = 0; n_apply = 0; n_undo = 0;
      prune_err = 0; undo_err = 0; stab_err = 0;
      prev_stall = 1'b0;
    end else begin
      if (rst_n && prev_stall &&
          !(op_valid && op_face == pf && op_turn == pt && op_undo == pu))
        stab_err++;
      case (ready_mode)
        0:       op_ready = 1'b1;
        1:       op_ready = ($urandom_range(99) < 30);
        default: op_ready = 1'b0;
      endcase
      if (rst_n && op_valid && op_ready) begin
        if (!op_undo) begin
          n_apply++;
          if (m_depth > 0 && m_face[m_depth-1] == op_face) prune_err++;
          if (op_face > 3'd5 || op_turn == 2'd0 || m_depth >= 15) prune_err++;
          else begin
            m_face[m_depth] = op_face;
            m_turn[m_depth] = op_turn;
            m_depth++;
          end
        end else begin
          n_undo++;
          if (m_depth == 0 || m_face[m_depth-1] != op_face || m_turn[m_depth-1] != op_turn)
            undo_err++;
          else
            m_depth--;
        end
      end
      prev_stall = rst_n && op_valid && !op_ready;
      pf = op_face; pt = op_turn; pu = op_undo;
    end
    match = (m_depth == tgt_len);
    for (int i = 0; i < 4; i++)
      if (i < tgt_len && i < m_depth && (m_face[i] != tgt_face[i] || m_turn[i] != tgt_turn[i]))
        match = 1'b0;
    solved_m = match;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic start_run(input bit use2);
    @(posedge clk); #1;
    if (use2) run2 = 1'b1; else run8 = 1'b1;
    @(posedge clk); #1;
    run8 = 1'b0; run2 = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (!done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_timeout"}, int'(done), 1);
  endtask

  typedef struct {
    bit              use2;
    bit              tie;
    int              rmode;
    int              tlen;
    logic [1:0][2:0] tf;
    logic [1:0][1:0] tt;
    int              exp_found;
    int              exp_depth;
    int              exp_apply;
    int              exp_undo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // depth-1 target (2,3): faces 0,1 x 3 turns + face 2 turns 1..3 = 9 applies.
    // depth-2 target (0,2),(1,1): 18 at limit 1, then (0,1)+15 children+(0,2)+(1,1).
    // exhaustion at MAX_DEPTH=2: 18 + 18*16 = 306 applies and undos.
    vecs[0] = '{1'b0, 1'b1, 0, 0, {3'd0, 3'd0}, {2'd0, 2'd0}, 1, 0, 0, 0};
    vecs[1] = '{1'b0, 1'b0, 0, 1, {3'd0, 3'd2}, {2'd0, 2'd3}, 1, 1, 9, 8};
    vecs[2] = '{1'b0, 1'b0, 0, 2, {3'd1, 3'd0}, {2'd1, 2'd2}, 1, 2, 36, 34};
    vecs[3] = '{1'b1, 1'b0, 0, 3, {3'd0, 3'd0}, {2'd1, 2'd1}, 0, 0, 306, 306};
    vecs[4] = '{1'b0, 1'b0, 1, 1, {3'd0, 3'd2}, {2'd0, 2'd3}, 1, 1, 9, 8};
    vecs[5] = '{1'b0, 1'b0, 1, 2, {3'd1, 3'd0}, {2'd1, 2'd2}, 1, 2, 36, 34};

    rst_n = 1'b0; run8 = 1'b0; run2 = 1'b0; sel2 = 1'b0; rd_addr = '0;
    tie_solved = 1'b0; ready_mode = 0; tgt_len = 1;
    for (int i = 0; i < 4; i++) begin tgt_face[i] = '0; tgt_turn[i] = '0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst_op_valid", int'(op_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_rd_turn", int'(rd_turn), 0);
    rst_n = 1'b1;

    // Already solved: busy right after the sampling edge, done one edge later.
    tie_solved = 1'b1;
    @(posedge clk); #1;
    run8 = 1'b1;
    @(posedge clk); #1;
    run8 = 1'b0;
    check("solved_busy_k", int'(busy), 1);
    check("solved_done_k", int'(done), 0);
    @(posedge clk); #1;
    check("solved_done_k1", int'(done), 1);
    check("solved_found", int'(found), 1);
    check("solved_depth", int'(depth), 0);
    check("solved_applies", n_apply, 0);
    $display("seq solved: done=%0d found=%0d depth=%0d", done, found, depth);
    tie_solved = 1'b0;

    // Reset in the middle of a stalled APPLY.
    ready_mode = 2; tgt_len = 1; tgt_face[0] = 3'd2; tgt_turn[0] = 2'd3;
    start_run(1'b0);
    for (int c = 0; c < 50 && !op_valid; c++) begin @(posedge clk); #1; end
    check("rst_mid_valid_before", int'(op_valid), 1);
    check("rst_mid_depth_before", int'(depth), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_op_valid", int'(op_valid), 0);
    check("rst_mid_op_turn", int'(op_turn), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_depth", int'(depth), 0);
    check("rst_mid_stall_stable", stab_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_op_valid", int'(op_valid), 0);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_done", int'(done), 0);
    $display("seq reset: op_valid=%0d busy=%0d done=%0d", op_valid, busy, done);

    // Table of complete searches.
    for (int k = 0; k < 6; k++) begin
      tie_solved = vecs[k].tie;
      ready_mode = vecs[k].rmode;
      tgt_len    = vecs[k].tlen;
      for (int i = 0; i < 4; i++) begin
        tgt_face[i] = (i < 2) ? vecs[k].tf[i] : 3'd0;
        tgt_turn[i] = (i < 2) ? vecs[k].tt[i] : 2'd0;
      end
      sel2 = vecs[k].use2;
      start_run(vecs[k].use2);
      wait_done($sformatf("v%0d", k));
      check($sformatf("v%0d_busy", k), int'(busy), 0);
      check($sformatf("v%0d_found", k), int'(found), vecs[k].exp_found);
      if (vecs[k].exp_found != 0)
        check($sformatf("v%0d_depth", k), int'(depth), vecs[k].exp_depth);
      check($sformatf("v%0d_applies", k), n_apply, vecs[k].exp_apply);
      check($sformatf("v%0d_undos", k), n_undo, vecs[k].exp_undo);
      check($sformatf("v%0d_model_lv", k), m_depth, vecs[k].exp_depth);
      check($sformatf("v%0d_prune", k), prune_err, 0);
      check($sformatf("v%0d_undo_match", k), undo_err, 0);
      check($sformatf("v%0d_stall_stable", k), stab_err, 0);
      for (int i = 0; i < vecs[k].exp_depth; i++) begin
        rd_addr = 4'(i);
        #1;
        check($sformatf("v%0d_rd_face%0d", k, i), int'(rd_face), int'(vecs[k].tf[i]));
        check($sformatf("v%0d_rd_turn%0d", k, i), int'(rd_turn), int'(vecs[k].tt[i]));
      end
      $display("vec %0d: found=%0d depth=%0d applies=%0d undos=%0d", k, found, depth, n_apply, n_undo);
      tie_solved = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
